int8_to_int32_expander: RTL and testbench

Streaming dequantizer that turns packed int8 words back into int32 values for the accumulator and host-readback path. It is the inverse of the output requantization stage. Each accepted input beat carries LANES signed int8 values and a power-of-two scale word. The block emits one sign-extended, left-shifted int32 per cycle, lane 0 first, with valid/ready handshakes on both sides and full throughput across back-to-back words.

---
 rtl/int8_to_int32_expander.sv | 100 ++++++++++
 tb/tb_int8_to_int32_expander.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/int8_to_int32_expander.sv
// Streaming int8 -> int32 dequantizer: holds one packed beat of LANES int8 values
// and emits them lane 0 first, sign-extended and shifted by a power-of-two scale.
module int8_to_int32_expander #(
  parameter int LANES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [8*LANES-1:0]       in_data,
  input  logic [31:0]              in_scale,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_data,
  output logic [$clog2(LANES)-1:0] out_lane,
  output logic                     out_last
);

  localparam int LW = $clog2(LANES);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t             r_state;
  logic [8*LANES-1:0] r_word;
  logic [4:0]         r_sh;
  logic [LW-1:0]      r_lane;

  logic [4:0]  w_sh;
  logic        w_busy;
  logic        w_last_lane;
  logic        w_out_hs;
  logic        w_accept;
  logic [7:0]  w_lane_byte;
  logic [31:0] w_lane_ext;

  // Highest decoded scale bit wins; every other scale bit is ignored.
  always_comb begin
    w_sh = 5'd0;
    if (in_scale[16])     w_sh = 5'd16;
    else if (in_scale[8]) w_sh = 5'd8;
    else if (in_scale[4]) w_sh = 5'd4;
    else if (in_scale[2]) w_sh = 5'd2;
    else if (in_scale[1]) w_sh = 5'd1;
  end

  assign w_busy      = (r_state == ST_BUSY);
  assign w_last_lane = (r_lane == LW'(LANES - 1));
  assign w_out_hs    = w_busy && out_ready;
  assign w_accept    = in_valid && in_ready;

  // A new beat is only taken while BUSY when the last lane leaves the same cycle.
  assign in_ready = !rst && (!w_busy || (out_ready && w_last_lane));

  assign w_lane_byte = r_word[8*r_lane +: 8];
  assign w_lane_ext  = {{24{w_lane_byte[7]}}, w_lane_byte};

  assign out_valid = w_busy;
  assign out_data  = w_busy ? (w_lane_ext << r_sh) : 32'd0;
  assign out_lane  = w_busy ? r_lane : '0;
  assign out_last  = w_busy && w_last_lane;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_word  <= '0;
      r_sh    <= 5'd0;
      r_lane  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_word  <= in_data;
            r_sh    <= w_sh;
            r_lane  <= '0;
            r_state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (w_out_hs) begin
            if (!w_last_lane) begin
              r_lane <= r_lane + LW'(1);
            end else if (w_accept) begin
              r_word <= in_data;
              r_sh   <= w_sh;
              r_lane <= '0;
            end else begin
              r_lane  <= '0;
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_int8_to_int32_expander.sv
// Bench for int8_to_int32_expander: directed cases plus a randomized round-trip
// against a queue-based model of the expected lane stream.
module tb_int8_to_int32_expander;

  localparam int LANES = 4;
  localparam int LW    = $clog2(LANES);

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [8*LANES-1:0]   in_data;
  logic [31:0]          in_scale;
  logic                 out_valid;
  logic                 out_ready;
  logic [31:0]          out_data;
  logic [LW-1:0]        out_lane;
  logic                 out_last;

  int checks = 0;
  int errors = 0;
  int beats_done = 0;
  int cycles = 0;

  typedef struct {
    int data;
    int lane;
    bit last;
    int x;
    int sh;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  int8_to_int32_expander #(.LANES(LANES)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_scale(in_scale),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_lane(out_lane), .out_last(out_last)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int decode_sh(input logic [31:0] s);
    if (s[16]) return 16;
    if (s[8])  return 8;
    if (s[4])  return 4;
    if (s[2])  return 2;
    if (s[1])  return 1;
    return 0;
  endfunction

  // Evaluate the current cycle against the model, then advance to the next negedge.
  task automatic step();
    exp_t e;
    #1;
    if (rst) begin
      chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
      q.delete();
    end else begin
      chk("out_valid", {63'd0, out_valid}, {63'd0, q.size() != 0});
      chk("in_ready", {63'd0, in_ready},
          {63'd0, (q.size() == 0) || (out_ready && q.size() == 1)});
      if (!out_valid)
        chk("idle_outputs", {29'd0, out_data, out_lane, out_last}, 64'd0);
      if (out_valid && out_ready && q.size() > 0) begin
        e = q.pop_front();
        chk("out_data", {32'd0, out_data}, {32'd0, e.data});
        chk("out_lane", {62'd0, out_lane}, e.lane);
        chk("out_last", {63'd0, out_last}, {63'd0, e.last});
        chk("roundtrip", ($signed(out_data) >>> e.sh), e.x);
        if (e.last) beats_done++;
      end
      if (in_valid && in_ready) begin
        for (int k = 0; k < LANES; k++) begin
          byte b;
          b = in_data[8*k +: 8];
          e.x    = int'(b);
          e.sh   = decode_sh(in_scale);
          e.data = e.x * (1 << e.sh);
          e.lane = k;
          e.last = (k == LANES - 1);
          q.push_back(e);
        end
      end
    end
    @(negedge clk);
    cycles++;
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (q.size() != 0 && n < 50) begin
      step();
      n++;
    end
    if (q.size() != 0) chk("drain_timeout", q.size(), 0);
  endtask

  task automatic send(input logic [31:0] d, input logic [31:0] s);
    in_valid = 1'b1;
    in_data  = d;
    in_scale = s;
    step();
    in_valid = 1'b0;
  endtask

  logic [31:0] scales_t [5] = '{32'h0001_0000, 32'h0001_0100, 32'h0000_0002,
                                32'h0000_0008, 32'h0000_0000};
  int          scales_v [5] = '{327680, 327680, 10, 5, 5};
  logic [31:0] rnd_scales [7] = '{32'd1, 32'd2, 32'd4, 32'd8, 32'd16, 32'd256, 32'd65536};
  int          basic_v  [4] = '{256, -256, 32512, -32768};

  initial begin
    logic [31:0] hold_d;
    logic [LW-1:0] hold_l;
    int budget;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_scale = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    step();
    rst = 1'b0;
    #1;
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_out_data", {32'd0, out_data}, 64'd0);
    chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
    step();

    // Basic word, sh=8
    send(32'h807F_FF01, 32'h0000_0100);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("basic_data", {32'd0, out_data}, {32'd0, basic_v[i]});
      chk("basic_last", {63'd0, out_last}, {63'd0, i == 3});
      step();
    end
    #1 chk("basic_idle", {63'd0, out_valid}, 64'd0);
    step();

    // Shift decode
    for (int i = 0; i < 5; i++) begin
      send(32'h0000_0005, scales_t[i]);
      #1 chk("shift_decode", {32'd0, out_data}, {32'd0, scales_v[i]});
      drain();
    end

    // Back-to-back with no bubble
    in_valid = 1'b1; in_data = 32'h0403_0201; in_scale = 32'd0;
    step();
    in_data = 32'h0807_0605;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) in_valid = 1'b0;
      #1;
      chk("b2b_data", {32'd0, out_data}, i + 1);
      chk("b2b_in_ready", {63'd0, in_ready}, {63'd0, (i == 3) || (i == 7)});
      step();
    end
    drain();

    // Backpressure on lane1
    send(32'hC3B2_A190, 32'h0000_0010);
    step();
    #1; hold_d = out_data; hold_l = out_lane;
    chk("bp_lane", {62'd0, out_lane}, 64'd1);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_data_stable", {32'd0, out_data}, {32'd0, hold_d});
      chk("bp_lane_stable", {62'd0, out_lane}, {62'd0, hold_l});
      chk("bp_last_stable", {63'd0, out_last}, 64'd0);
      chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
      step();
    end
    in_valid = 1'b0;
    drain();

    // Reset while lane2 is pending
    send(32'h1122_3344, 32'h0000_0002);
    step();
    step();
    #1 chk("rst_mid_lane", {62'd0, out_lane}, 64'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("rst_mid_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_mid_data", {32'd0, out_data}, 64'd0);
    chk("rst_mid_lane0", {62'd0, out_lane}, 64'd0);
    chk("rst_mid_in_ready", {63'd0, in_ready}, 64'd1);
    step();
    send(32'h0000_0077, 32'h0000_0000);
    #1;
    chk("rst_new_lane", {62'd0, out_lane}, 64'd0);
    chk("rst_new_data", {32'd0, out_data}, 64'h77);
    drain();

    // Randomized round-trip
    beats_done = 0;
    budget = cycles + 80000;
    while (beats_done < 10000 && cycles < budget) begin
      in_valid  = ($urandom_range(9) != 0);
      out_ready = ($urandom_range(9) != 0);
      in_data   = $urandom;
      in_scale  = rnd_scales[$urandom_range(6)];
      step();
    end
    if (beats_done < 10000) chk("random_timeout", beats_done, 10000);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
